// File: rtl/dm_stage_bhw.sv
// dm_stage_bhw: MEM-stage data memory with registered MEM/WB outputs.
// Decodes lw/lh/lhu/lb/lbu/sw/sh/sb from instrMEM. It flags out-of-range and
// misaligned accesses and clears the array with a post-reset sweep.
// Ports:
//   clk, reset (async, active-low)
//   instrMEM, rtdataMEM, aluOutMEM, pcMEM             - MEM-stage instruction context
//   RegDataMEM, RegAddrMEM, RegWriteMEM               - pass-through result
//   RegDataWB, RegAddrWB, RegWriteWB, addrErr         - registered write-back stage
//   stall                                             - high while the clear sweep runs
module dm_stage_bhw #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrMEM,
    input  logic [31:0] rtdataMEM,
    input  logic [31:0] aluOutMEM,
    input  logic [31:0] pcMEM,
    input  logic [31:0] RegDataMEM,
    input  logic [4:0]  RegAddrMEM,
    input  logic        RegWriteMEM,
    output logic [31:0] RegDataWB,
    output logic [4:0]  RegAddrWB,
    output logic        RegWriteWB,
    output logic        stall,
    output logic        addrErr
);

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [31:0]   regdata_wb_q, regdata_wb_d;
    logic [4:0]    regaddr_wb_q, regaddr_wb_d;
    logic          regwrite_wb_q, regwrite_wb_d;
    logic          addr_err_q, addr_err_d;

    logic [31:0]   mem [DEPTH];

    logic [5:0]    op_c;
    logic [4:0]    rt_c;
    logic [1:0]    lane_c;
    logic [AW-1:0] widx_c;
    logic          is_load_c, is_store_c, sz_word_c, sz_half_c, ld_signed_c;
    logic          oor_c, misalign_c, fault_c;
    logic [31:0]   rdata_c, wmerge_c, ldata_c;
    logic [15:0]   rhalf_c;
    logic [7:0]    rbyte_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_waddr_c;
    logic [31:0]   mem_wdata_c;
    logic          unused_c;

    assign op_c     = instrMEM[31:26];
    assign rt_c     = instrMEM[20:16];
    assign lane_c   = aluOutMEM[1:0];
    assign widx_c   = aluOutMEM[AW+1:2];
    assign unused_c = ^{instrMEM[25:21], instrMEM[15:0], pcMEM};

    // Opcode decode into access class, size and extension.
    always_comb begin
        is_load_c   = 1'b0;
        is_store_c  = 1'b0;
        sz_word_c   = 1'b0;
        sz_half_c   = 1'b0;
        ld_signed_c = 1'b0;
        case (op_c)
            OP_LW:   begin is_load_c = 1'b1; sz_word_c = 1'b1; end
            OP_LH:   begin is_load_c = 1'b1; sz_half_c = 1'b1; ld_signed_c = 1'b1; end
            OP_LHU:  begin is_load_c = 1'b1; sz_half_c = 1'b1; end
            OP_LB:   begin is_load_c = 1'b1; ld_signed_c = 1'b1; end
            OP_LBU:  begin is_load_c = 1'b1; end
            OP_SW:   begin is_store_c = 1'b1; sz_word_c = 1'b1; end
            OP_SH:   begin is_store_c = 1'b1; sz_half_c = 1'b1; end
            OP_SB:   begin is_store_c = 1'b1; end
            default: begin end
        endcase
    end

    // Fault detection: address bits above the array, or lane not size-aligned.
    assign oor_c      = |aluOutMEM[31:AW+2];
    assign misalign_c = (sz_word_c && (lane_c != 2'b00)) || (sz_half_c && lane_c[0]);
    assign fault_c    = (is_load_c || is_store_c) && (oor_c || misalign_c);

    assign rdata_c = mem[widx_c];

    // Store merge (read-modify-write of the addressed word) and load extract.
    always_comb begin
        wmerge_c = rdata_c;
        if (sz_word_c) begin
            wmerge_c = rtdataMEM;
        end else if (sz_half_c) begin
            if (lane_c[1]) wmerge_c[31:16] = rtdataMEM[15:0];
            else           wmerge_c[15:0]  = rtdataMEM[15:0];
        end else begin
            wmerge_c[{lane_c, 3'b000} +: 8] = rtdataMEM[7:0];
        end

        rhalf_c = lane_c[1] ? rdata_c[31:16] : rdata_c[15:0];
        rbyte_c = rdata_c[{lane_c, 3'b000} +: 8];
        if (sz_word_c)      ldata_c = rdata_c;
        else if (sz_half_c) ldata_c = {{16{ld_signed_c & rhalf_c[15]}}, rhalf_c};
        else                ldata_c = {{24{ld_signed_c & rbyte_c[7]}}, rbyte_c};
    end

    // Single write port shared by the clear sweep and committed stores.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = widx_c;
        mem_wdata_c = wmerge_c;
        if (state_q == ST_CLEAR) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = cnt_q;
            mem_wdata_c = 32'h0;
        end else if (is_store_c && !fault_c) begin
            mem_we_c = 1'b1;
        end
    end

    // Sweep FSM next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = AW'(cnt_q + 1'b1);
            if (cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
        end
    end

    // MEM/WB next values; a bubble is inserted while the sweep runs.
    always_comb begin
        regdata_wb_d  = 32'h0;
        regaddr_wb_d  = 5'd0;
        regwrite_wb_d = 1'b0;
        addr_err_d    = 1'b0;
        if (state_q == ST_RUN) begin
            addr_err_d = fault_c;
            if (is_load_c) begin
                regdata_wb_d  = ldata_c;
                regaddr_wb_d  = rt_c;
                regwrite_wb_d = !fault_c && (rt_c != 5'd0);
            end else begin
                regdata_wb_d  = RegDataMEM;
                regaddr_wb_d  = RegAddrMEM;
                regwrite_wb_d = RegWriteMEM;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_CLEAR;
            cnt_q         <= '0;
            regdata_wb_q  <= 32'h0;
            regaddr_wb_q  <= 5'd0;
            regwrite_wb_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            regdata_wb_q  <= regdata_wb_d;
            regaddr_wb_q  <= regaddr_wb_d;
            regwrite_wb_q <= regwrite_wb_d;
            addr_err_q    <= addr_err_d;
        end
    end

    // Storage array: no reset, contents are defined by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
    end

    assign RegDataWB  = regdata_wb_q;
    assign RegAddrWB  = regaddr_wb_q;
    assign RegWriteWB = regwrite_wb_q;
    assign addrErr    = addr_err_q;
    assign stall      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dm_stage_bhw.sv
// Directed testbench for dm_stage_bhw with DEPTH = 16.
module tb_dm_stage_bhw;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    logic        clk;
    logic        reset;
    logic [31:0] instrMEM, rtdataMEM, aluOutMEM, pcMEM, RegDataMEM;
    logic [4:0]  RegAddrMEM;
    logic        RegWriteMEM;
    logic [31:0] RegDataWB;
    logic [4:0]  RegAddrWB;
    logic        RegWriteWB, stall, addrErr;

    int total = 0;
    int bad   = 0;

    dm_stage_bhw #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .instrMEM    (instrMEM),
        .rtdataMEM   (rtdataMEM),
        .aluOutMEM   (aluOutMEM),
        .pcMEM       (pcMEM),
        .RegDataMEM  (RegDataMEM),
        .RegAddrMEM  (RegAddrMEM),
        .RegWriteMEM (RegWriteMEM),
        .RegDataWB   (RegDataWB),
        .RegAddrWB   (RegAddrWB),
        .RegWriteWB  (RegWriteWB),
        .stall       (stall),
        .addrErr     (addrErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [5:0] op, input logic [4:0] rt,
                          input logic [31:0] addr, input logic [31:0] wd);
        instrMEM    = {op, 5'd0, rt, 16'd0};
        aluOutMEM   = addr;
        rtdataMEM   = wd;
        pcMEM       = pcMEM + 32'd4;
        RegDataMEM  = 32'h0;
        RegAddrMEM  = 5'd0;
        RegWriteMEM = 1'b0;
    endtask

    task automatic do_op(input logic [5:0] op, input logic [4:0] rt,
                         input logic [31:0] addr, input logic [31:0] wd);
        set_op(op, rt, addr, wd);
        tick();
    endtask

    // Committed store with the expected merged word, logged in store-log format.
    task automatic do_store(input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] merged);
        set_op(op, 5'd9, addr, wd);
        $display("%d@%h: *%h <= %h", $time, pcMEM, {addr[31:2], 2'b00}, merged);
        tick();
    endtask

    task automatic chk_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] exp);
        do_op(op, 5'd3, addr, 32'h0);
        chk(tag, RegDataWB, exp);
        chk({tag, "_we"}, 32'(RegWriteWB), 32'd1);
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 1; i < int'(DEPTH); i++) tick();
        chk({tag, "_stall_hi"}, 32'(stall), 32'd1);
        tick();
        chk({tag, "_stall_lo"}, 32'(stall), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        pcMEM = 32'h0040_0000;
        set_op(OP_NOP, 5'd0, 32'h0, 32'h0);
        #3;
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_data", RegDataWB, 32'h0);
        chk("rst_we", 32'(RegWriteWB), 32'd0);
        chk("rst_addr", 32'(RegAddrWB), 32'd0);
        chk("rst_err", 32'(addrErr), 32'd0);

        // Release between edges; drive a live pass-through that must be bubbled.
        tick();
        reset = 1'b1;
        RegDataMEM = 32'h55; RegAddrMEM = 5'd7; RegWriteMEM = 1'b1;
        tick();
        chk("sweep_bubble_we", 32'(RegWriteWB), 32'd0);
        chk("sweep_bubble_data", RegDataWB, 32'h0);
        RegWriteMEM = 1'b0;
        for (int i = 2; i < int'(DEPTH); i++) tick();
        chk("sweep_stall_hi", 32'(stall), 32'd1);
        tick();
        chk("sweep_stall_lo", 32'(stall), 32'd0);

        for (int i = 0; i < int'(DEPTH); i++) begin
            do_op(OP_LW, 5'd1, 32'(i * 4), 32'h0);
            chk($sformatf("clear_w%0d", i), RegDataWB, 32'h0);
        end

        do_store(OP_SW, 32'h8, 32'h1122_3344, 32'h1122_3344);
        chk("sw_err", 32'(addrErr), 32'd0);
        chk_load("lw8_b2b", OP_LW, 32'h8, 32'h1122_3344);
        chk("lw8_rt", 32'(RegAddrWB), 32'd3);
        do_store(OP_SB, 32'h9, 32'h1234_56AA, 32'h1122_AA44);
        chk_load("lw8_after_sb", OP_LW, 32'h8, 32'h1122_AA44);
        chk_load("lb9", OP_LB, 32'h9, 32'hFFFF_FFAA);
        chk_load("lbu9", OP_LBU, 32'h9, 32'h0000_00AA);

        do_store(OP_SH, 32'h6, 32'hFFFF_8001, 32'h8001_0000);
        chk_load("lh6", OP_LH, 32'h6, 32'hFFFF_8001);
        chk_load("lhu6", OP_LHU, 32'h6, 32'h0000_8001);
        chk_load("lw4", OP_LW, 32'h4, 32'h8001_0000);

        do_op(OP_SW, 5'd9, 32'h2, 32'hDEAD_BEEF);
        chk("sw_mis_err", 32'(addrErr), 32'd1);
        do_op(OP_NOP, 5'd0, 32'h0, 32'h0);
        chk("sw_mis_err_pulse", 32'(addrErr), 32'd0);
        chk_load("lw0_unchanged", OP_LW, 32'h0, 32'h0);

        do_op(OP_LH, 5'd4, 32'h3, 32'h0);
        chk("lh_mis_we", 32'(RegWriteWB), 32'd0);
        chk("lh_mis_err", 32'(addrErr), 32'd1);
        do_op(OP_LW, 5'd5, 32'(DEPTH * 4), 32'h0);
        chk("lw_oor_err", 32'(addrErr), 32'd1);
        chk("lw_oor_we", 32'(RegWriteWB), 32'd0);

        set_op(OP_NOP, 5'd0, 32'h0, 32'h0);
        RegDataMEM = 32'h5; RegAddrMEM = 5'd7; RegWriteMEM = 1'b1;
        tick();
        chk("pass_data", RegDataWB, 32'h5);
        chk("pass_addr", 32'(RegAddrWB), 32'd7);
        chk("pass_we", 32'(RegWriteWB), 32'd1);
        chk("pass_err", 32'(addrErr), 32'd0);

        do_op(OP_LW, 5'd0, 32'h8, 32'h0);
        chk("lw_r0_we", 32'(RegWriteWB), 32'd0);

        // Asynchronous reset while outputs hold a live value.
        set_op(OP_NOP, 5'd0, 32'h0, 32'h0);
        RegDataMEM = 32'hCAFE; RegAddrMEM = 5'd12; RegWriteMEM = 1'b1;
        tick();
        chk("pre_rst_data", RegDataWB, 32'hCAFE);
        reset = 1'b0;
        #2;
        chk("async_rst_data", RegDataWB, 32'h0);
        chk("async_rst_addr", 32'(RegAddrWB), 32'd0);
        chk("async_rst_we", 32'(RegWriteWB), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        set_op(OP_NOP, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        #2;
        chk("midsweep_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        sweep_check("resweep");
        chk_load("lw8_recleared", OP_LW, 32'h8, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
